// File: rtl/ntt_pass_ctrl_if.sv
// Scheduler/PE-fabric bundle of the NTT pass controller.
// The scheduler (or a bench) takes the master side; the controller takes the slave side.
interface ntt_pass_ctrl_if #(
   parameter int ADDR_W = 7,
   parameter int TW_W   = 8
);
   logic              start;
   logic [2:0]        mode;
   logic              KD_mode;
   logic              sel_1;
   logic              sel_0;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [TW_W-1:0]   tw_addr;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr_a;
   logic [ADDR_W-1:0] wb_addr_b;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, mode,
      input  KD_mode, sel_1, sel_0, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
             wb_valid, wb_addr_a, wb_addr_b, busy, done, err
   );

   modport slave (
      input  start, mode,
      output KD_mode, sel_1, sel_0, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
             wb_valid, wb_addr_a, wb_addr_b, busy, done, err
   );
endinterface

// File: rtl/ntt_pass_ctrl.sv
// Pass/butterfly sequencer for the PE1 butterfly datapath: issues bank and twiddle
// addresses for every pass and replays them as write-back addresses after the PE latency.
module ntt_pass_ctrl #(
   parameter int ADDR_W      = 7,
   parameter int TW_W        = 8,
   parameter int LAT_NTT     = 4,
   parameter int LAT_INTT    = 15,
   parameter int K_R2_PASSES = 7,
   parameter int K_R4_PASSES = 4,
   parameter int D_PASSES    = 7
) (
   input  logic           clk,
   input  logic           rst,
   ntt_pass_ctrl_if.slave bus
);
   localparam int J_W     = ADDR_W - 1;
   localparam int LAT_MAX = (LAT_NTT > LAT_INTT) ? LAT_NTT : LAT_INTT;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);
   localparam logic [J_W-1:0] J_LAST = {J_W{1'b1}};

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t            state_r, state_s;
   logic [2:0]        mode_r, mode_s;
   logic [2:0]        pass_r, pass_s;
   logic [J_W-1:0]    j_r, j_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [CNT_W-1:0]  lat_m1_s;
   logic [2:0]        pass_last_s;
   logic [2:0]        q_s;
   logic              illegal_s;
   logic              accept_s;
   logic              issue_s;
   logic              active_s;
   logic [ADDR_W-1:0] addr_a_s;
   logic [ADDR_W-1:0] addr_b_s;
   logic [TW_W-1:0]   tw_s;

   logic              kd_r, sel1_r, sel0_r;
   logic              rd_valid_r;
   logic [ADDR_W-1:0] rd_addr_a_r, rd_addr_b_r;
   logic [TW_W-1:0]   tw_addr_r;
   logic              wb_valid_r;
   logic [ADDR_W-1:0] wb_addr_a_r, wb_addr_b_r;
   logic              busy_r, done_r, err_r;

   logic              dl_v_r [LAT_MAX];
   logic [ADDR_W-1:0] dl_a_r [LAT_MAX];
   logic [ADDR_W-1:0] dl_b_r [LAT_MAX];

   // Stride bit for a pass: radix-2 steps by one bit, radix-4 by two, clamped to the word range.
   function automatic logic [2:0] stride_q(input logic inv, input logic r4, input logic [2:0] p);
      logic [3:0] two_p;
      logic [2:0] q;
      two_p = {p, 1'b0};
      case ({inv, r4})
         2'b00:   q = 3'(J_W) - p;
         2'b10:   q = p;
         2'b01:   q = (two_p >= 4'(J_W)) ? 3'd0 : 3'(4'(J_W) - two_p);
         2'b11:   q = (two_p >= 4'(J_W)) ? 3'(J_W) : two_p[2:0];
         default: q = 3'd0;
      endcase
      return q;
   endfunction

   function automatic logic [ADDR_W-1:0] insert_bit(input logic [J_W-1:0] j, input logic [2:0] q,
                                                    input logic b);
      logic [ADDR_W-1:0] jw;
      logic [ADDR_W-1:0] low_mask;
      jw       = {1'b0, j};
      low_mask = (ADDR_W'(1) << q) - ADDR_W'(1);
      return ((jw & ~low_mask) << 1) | (jw & low_mask) | (ADDR_W'(b) << q);
   endfunction

   function automatic logic [TW_W-1:0] tw_index(input logic [J_W-1:0] j, input logic [2:0] q);
      return (TW_W'(1) << (3'(J_W) - q)) + TW_W'(j >> q);
   endfunction

   assign illegal_s   = bus.mode[2] & bus.mode[0];
   assign accept_s    = (state_r == IDLE) & bus.start & ~illegal_s;
   assign lat_m1_s    = mode_r[1] ? CNT_W'(LAT_INTT - 1) : CNT_W'(LAT_NTT - 1);
   assign pass_last_s = mode_r[0] ? 3'(K_R4_PASSES - 1) :
                        (mode_r[2] ? 3'(D_PASSES - 1) : 3'(K_R2_PASSES - 1));

   // Next-state, pass/butterfly counters and drain timer.
   always_comb begin
      state_s = state_r;
      mode_s  = mode_r;
      pass_s  = pass_r;
      j_s     = j_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = ISSUE;
               mode_s  = bus.mode;
               pass_s  = 3'd0;
               j_s     = {J_W{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            j_s = j_r + {{(J_W-1){1'b0}}, 1'b1};
            if (j_r == J_LAST) begin
               state_s = DRAIN;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = ISSUE;
            end
         end
         DRAIN: begin
            // The drain length equals the PE latency, so the last write of a pass lands
            // before the first read of the next one.
            if (cnt_r == lat_m1_s) begin
               if (pass_r != pass_last_s) begin
                  state_s = ISSUE;
                  pass_s  = pass_r + 3'd1;
                  j_s     = {J_W{1'b0}};
               end else begin
                  state_s = DONE;
               end
            end else begin
               cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   assign issue_s  = (state_s == ISSUE);
   assign active_s = (state_s != IDLE);
   assign q_s      = stride_q(mode_s[1], mode_s[0], pass_s);
   assign addr_a_s = issue_s ? insert_bit(j_s, q_s, 1'b0) : {ADDR_W{1'b0}};
   assign addr_b_s = issue_s ? insert_bit(j_s, q_s, 1'b1) : {ADDR_W{1'b0}};
   assign tw_s     = issue_s ? tw_index(j_s, q_s) : {TW_W{1'b0}};

   // State, counters, registered outputs and the write-back delay line.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         mode_r      <= 3'd0;
         pass_r      <= 3'd0;
         j_r         <= {J_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         kd_r        <= 1'b0;
         sel1_r      <= 1'b0;
         sel0_r      <= 1'b0;
         rd_valid_r  <= 1'b0;
         rd_addr_a_r <= {ADDR_W{1'b0}};
         rd_addr_b_r <= {ADDR_W{1'b0}};
         tw_addr_r   <= {TW_W{1'b0}};
         wb_valid_r  <= 1'b0;
         wb_addr_a_r <= {ADDR_W{1'b0}};
         wb_addr_b_r <= {ADDR_W{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         for (int i = 0; i < LAT_MAX; i++) begin
            dl_v_r[i] <= 1'b0;
            dl_a_r[i] <= {ADDR_W{1'b0}};
            dl_b_r[i] <= {ADDR_W{1'b0}};
         end
      end else begin
         state_r     <= state_s;
         mode_r      <= mode_s;
         pass_r      <= pass_s;
         j_r         <= j_s;
         cnt_r       <= cnt_s;
         kd_r        <= active_s & mode_s[2];
         sel1_r      <= active_s & mode_s[1];
         sel0_r      <= active_s & mode_s[0];
         rd_valid_r  <= issue_s;
         rd_addr_a_r <= addr_a_s;
         rd_addr_b_r <= addr_b_s;
         tw_addr_r   <= tw_s;
         busy_r      <= active_s;
         done_r      <= (state_s == DONE);
         err_r       <= (state_r == IDLE) & bus.start & illegal_s;
         // Stage 0 mirrors the read outputs; stage k holds the issue from k cycles ago.
         dl_v_r[0]   <= issue_s;
         dl_a_r[0]   <= addr_a_s;
         dl_b_r[0]   <= addr_b_s;
         for (int i = 1; i < LAT_MAX; i++) begin
            // Old entries beyond a shorter tap must not leak into a longer-latency run.
            dl_v_r[i] <= accept_s ? 1'b0 : dl_v_r[i-1];
            dl_a_r[i] <= accept_s ? {ADDR_W{1'b0}} : dl_a_r[i-1];
            dl_b_r[i] <= accept_s ? {ADDR_W{1'b0}} : dl_b_r[i-1];
         end
         wb_valid_r  <= mode_r[1] ? dl_v_r[LAT_INTT-1] : dl_v_r[LAT_NTT-1];
         wb_addr_a_r <= mode_r[1] ? dl_a_r[LAT_INTT-1] : dl_a_r[LAT_NTT-1];
         wb_addr_b_r <= mode_r[1] ? dl_b_r[LAT_INTT-1] : dl_b_r[LAT_NTT-1];
      end
   end

   assign bus.KD_mode   = kd_r;
   assign bus.sel_1     = sel1_r;
   assign bus.sel_0     = sel0_r;
   assign bus.rd_valid  = rd_valid_r;
   assign bus.rd_addr_a = rd_addr_a_r;
   assign bus.rd_addr_b = rd_addr_b_r;
   assign bus.tw_addr   = tw_addr_r;
   assign bus.wb_valid  = wb_valid_r;
   assign bus.wb_addr_a = wb_addr_a_r;
   assign bus.wb_addr_b = wb_addr_b_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
endmodule

// File: tb/tb_ntt_pass_ctrl.sv
// Self-checking bench for ntt_pass_ctrl: per-cycle comparison of every output against a
// timeline computed from the pass/stride/address rules with plain integer arithmetic.
module tb_ntt_pass_ctrl;
   logic clk;
   logic rst;
   int   n_vectors;
   int   n_miscompares;

   int iss_v  [0:1023];
   int iss_a  [0:1023];
   int iss_b  [0:1023];
   int iss_tw [0:1023];
   int ref_total;
   int ref_lat;
   int ref_passes;
   int legal_modes [6] = '{0, 1, 2, 3, 4, 6};

   ntt_pass_ctrl_if #(.ADDR_W(7), .TW_W(8)) bus ();

   ntt_pass_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] observe();
      return {20'd0, bus.busy, bus.done, bus.err, bus.KD_mode, bus.sel_1, bus.sel_0,
              bus.rd_valid, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
              bus.wb_valid, bus.wb_addr_a, bus.wb_addr_b};
   endfunction

   function automatic logic [63:0] pack(input int busy, input int done, input int err, input int m,
                                        input int rv, input int a, input int b, input int tw,
                                        input int wv, input int wa, input int wb);
      return {20'd0, 1'(busy), 1'(done), 1'(err), 3'(m), 1'(rv), 7'(a), 7'(b), 8'(tw),
              1'(wv), 7'(wa), 7'(wb)};
   endfunction

   function automatic int ref_q(input int m, input int p);
      int inv;
      int r4;
      inv = (m >> 1) & 1;
      r4  = m & 1;
      if (r4 == 0) return inv ? p : 6 - p;
      if (inv != 0) return (2 * p > 6) ? 6 : 2 * p;
      return (6 - 2 * p < 0) ? 0 : 6 - 2 * p;
   endfunction

   // Expected issue stream: index n is the n-th cycle after the accepting edge.
   task automatic build_model(input int m);
      int n;
      int q;
      ref_passes = ((m & 1) != 0) ? 4 : 7;
      ref_lat    = (((m >> 1) & 1) != 0) ? 15 : 4;
      ref_total  = ref_passes * (64 + ref_lat) + 1;
      for (int i = 0; i < 1024; i++) begin
         iss_v[i] = 0; iss_a[i] = 0; iss_b[i] = 0; iss_tw[i] = 0;
      end
      n = 1;
      for (int p = 0; p < ref_passes; p++) begin
         q = ref_q(m, p);
         for (int j = 0; j < 64; j++) begin
            iss_v[n]  = 1;
            iss_a[n]  = (j / (1 << q)) * (1 << (q + 1)) + (j % (1 << q));
            iss_b[n]  = iss_a[n] + (1 << q);
            iss_tw[n] = (1 << (6 - q)) + j / (1 << q);
            n++;
         end
         n += ref_lat;
      end
   endtask

   // Entered at the falling edge of cycle 1 of an accepted operation; upto=0 runs to done.
   task automatic check_op(input int m, input int upto, input bit noise);
      int lim;
      int k;
      int done_at;
      int wb_cnt;
      build_model(m);
      lim     = (upto == 0) ? ref_total : upto;
      done_at = 0;
      wb_cnt  = 0;
      for (int n = 1; n <= lim; n++) begin
         k = (n > ref_lat) ? n - ref_lat : 0;
         check_eq($sformatf("m%0d_cyc%0d", m, n), observe(),
                  pack(1, (n == ref_total) ? 1 : 0, 0, m, iss_v[n], iss_a[n], iss_b[n], iss_tw[n],
                       iss_v[k], iss_a[k], iss_b[k]));
         if (bus.done === 1'b1 && done_at == 0) done_at = n;
         if (bus.wb_valid === 1'b1) wb_cnt++;
         if (m == 0 && n == 6)
            check_eq("k2ntt_p0_j5", {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}, {7'd5, 7'd69, 8'd1});
         if (m == 0 && n == 6 * 68 + 6)
            check_eq("k2ntt_p6_j5", {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}, {7'd10, 7'd11, 8'd69});
         if (m == 3 && n == 79 + 4)
            check_eq("k4intt_p1_j3", {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}, {7'd3, 7'd7, 8'd16});
         if (noise) begin
            bus.start = ($urandom_range(0, 7) == 0);
            bus.mode  = 3'($urandom_range(0, 7));
         end
         if (n < lim) @(negedge clk);
      end
      if (upto == 0) begin
         check_eq($sformatf("m%0d_done_cycle", m), 64'(done_at), 64'(ref_total));
         check_eq($sformatf("m%0d_wb_count", m), 64'(wb_cnt), 64'(ref_passes * 64));
      end
   endtask

   task automatic idle_cycles(input int cnt, input string tag);
      for (int i = 0; i < cnt; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
         check_eq(tag, observe(), 64'd0);
      end
   endtask

   task automatic run_op(input int m, input bit noise);
      bus.start = 1'b1;
      bus.mode  = 3'(m);
      @(negedge clk);
      bus.start = 1'b0;
      bus.mode  = 3'($urandom_range(0, 7));
      check_op(m, 0, noise);
      idle_cycles(1, "after_done");
   endtask

   task automatic illegal_req(input int m);
      bus.start = 1'b1;
      bus.mode  = 3'(m);
      @(negedge clk);
      bus.start = 1'b0;
      check_eq($sformatf("illegal%0d_err", m), observe(), pack(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      idle_cycles(1, "illegal_after");
   endtask

   initial begin
      int m;
      n_vectors     = 0;
      n_miscompares = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.mode  = 3'd0;
      repeat (3) @(negedge clk);
      check_eq("reset_state", observe(), 64'd0);
      rst = 1'b1;
      idle_cycles(2, "idle_start");

      run_op(0, 1'b0);
      run_op(3, 1'b0);
      run_op(6, 1'b0);
      illegal_req(5);
      illegal_req(7);

      // Reset pulse at pass 2, j=30 of K_2_NTT, then a fresh full run.
      bus.start = 1'b1;
      bus.mode  = 3'd0;
      @(negedge clk);
      bus.start = 1'b0;
      check_op(0, 2 * 68 + 31, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_reset_outputs", observe(), 64'd0);
      rst = 1'b1;
      idle_cycles(20, "post_reset_quiet");
      run_op(0, 1'b0);

      // Start held high: one operation, the next accepted on the first IDLE cycle after done.
      bus.start = 1'b1;
      bus.mode  = 3'd1;
      @(negedge clk);
      check_op(1, 0, 1'b0);
      @(negedge clk);
      check_eq("held_start_idle_gap", observe(), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      check_op(1, 0, 1'b0);
      idle_cycles(1, "held_after");

      for (int it = 0; it < 6; it++) begin
         idle_cycles($urandom_range(0, 4), "rand_gap");
         if ($urandom_range(0, 2) == 0) illegal_req(($urandom_range(0, 1) == 0) ? 5 : 7);
         m = legal_modes[$urandom_range(0, 5)];
         run_op(m, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule

// File: doc/ntt_pass_ctrl.md
# ntt_pass_ctrl

Sequencing controller for the PE1 butterfly datapath. On a start request it drives the PE configuration selects (`KD_mode`, `sel_1`, `sel_0`) for the requested transform. It walks every pass and butterfly of a 256-coefficient polynomial, issuing coefficient-bank read addresses and twiddle addresses, and delays write-back addresses to match the PE pipeline latency of the selected mode. It sits between the top-level polynomial scheduler and the PE/bank fabric.

## Interface
- `ADDR_W`, 7, coefficient-bank word address width (128 words of two packed 12-bit coefficients)
- `TW_W`, 8, twiddle ROM address width
- `LAT_NTT`, 4, PE issue-to-result latency for NTT modes (`sel_1`=0)
- `LAT_INTT`, 15, PE issue-to-result latency for INTT modes (`sel_1`=1)
- `K_R2_PASSES`, 7, pass count for K_2_NTT / K_2_INTT
- `K_R4_PASSES`, 4, pass count for K_4_NTT / K_4_INTT
- `D_PASSES`, 7, pass count for D_2_NTT / D_2_INTT

Ports:
- `clk` in 1: clock; all logic on the rising edge
- `rst` in 1: synchronous, active-low reset
- `start` in 1: one-cycle request; sampled only in IDLE
- `mode` in 3: {KD, inv, r4}, sampled with `start`. Legal values: 000 K_2_NTT, 001 K_4_NTT, 010 K_2_INTT, 011 K_4_INTT, 100 D_2_NTT, 110 D_2_INTT. 101 and 111 are illegal.
- `KD_mode`, `sel_1`, `sel_0` out 1 each: PE configuration, equal to `mode` bits 2/1/0 while busy, 0 otherwise
- `rd_valid` out 1: read/issue strobe
- `rd_addr_a`, `rd_addr_b` out ADDR_W: butterfly operand word addresses
- `tw_addr` out TW_W: twiddle ROM address
- `wb_valid` out 1: write-back strobe
- `wb_addr_a`, `wb_addr_b` out ADDR_W: delayed copies of `rd_addr_a`/`rd_addr_b`
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle pulse at completion
- `err` out 1: one-cycle pulse when an illegal `mode` is requested

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start` with a legal mode: latch mode, p=0, j=0, go to ISSUE.
  - `start` with an illegal mode: pulse `err` next cycle, stay in IDLE.
  - `start` while not IDLE: ignored.
- ISSUE: one butterfly per cycle. `rd_valid`=1, j counts 0..63 (6 bits). At j=63, go to DRAIN.
- DRAIN: wait LAT cycles (LAT_NTT or LAT_INTT selected by the latched inv bit) so every write of pass p lands before pass p+1 reads. On expiry:
  - p+1 < PASSES: p++, j=0, go to ISSUE.
  - else: go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE. Selects drop to 0 in IDLE.
- Stride bit position q:
  - Radix-2 NTT: q = 6−p. Radix-2 INTT: q = p.
  - Radix-4 NTT: q = 6−2p, clamped to 0. Radix-4 INTT: q = 2p, clamped to 6.
- Address generation:
  - `rd_addr_a` = j with a 0 inserted at bit q.
  - `rd_addr_b` = j with a 1 inserted at bit q.
- `tw_addr` = (1 << (6−q)) + (j >> q), zero-extended to TW_W. The forward/inverse ROM table is selected externally by `sel_1`.
- Write-back path: a delay line of depth max(LAT_NTT, LAT_INTT) carries {valid, addr_a, addr_b}. The tap at the active LAT drives `wb_*`.
- Reset (`rst`=0 at a clock edge, including mid-operation): FSM goes to IDLE, counters clear, the delay line is flushed, and all outputs are 0. In-flight write-backs are discarded.

## Timing
- Every output resets to 0.
- Accepted `start` at edge t: `busy` and selects are valid from t+1; first `rd_valid` at t+1.
- `wb_valid` for an issue at cycle c: asserted at c+LAT, with identical addresses.
- Pass duration: 64 ISSUE + LAT DRAIN cycles.
- Total cycles from `start` to `done`: PASSES·(64+LAT) + 1.
  - K_2_NTT: 7·68+1 = 477
  - K_4_INTT: 4·79+1 = 317
  - D_2_INTT: 7·79+1 = 554
- `done` coincides with the last `wb_valid` having retired (DRAIN covers it). There is no overlap between consecutive operations.
- A `start` arriving in the same cycle as `done`: ignored. A new request is accepted from the next IDLE cycle.

## Test plan
- K_2_NTT (mode 000):
  - Selects = 0/0/0.
  - Pass 0, j=5: rd_a=5, rd_b=69, tw=1.
  - Pass 6, j=5: rd_a=10, rd_b=11, tw=69.
  - `done` at cycle 477; `wb_valid` count = 448.
- K_4_INTT (mode 011):
  - Selects = 0/1/1.
  - Pass 1, j=3: q=2, rd_a=3, rd_b=7, tw=16.
  - `wb_valid` exactly 15 cycles after each `rd_valid`.
  - `done` at cycle 317.
- D_2_INTT (mode 110): KD_mode=1, sel_1=1, sel_0=0 throughout; `done` at cycle 554.
- Illegal mode 101 or 111 with `start`: `err` pulse next cycle; `busy`, `rd_valid`, and selects stay 0.
- `rst` low for 1 cycle at pass 2, j=30 of K_2_NTT: all outputs 0 next cycle; no `wb_valid` after release; a fresh `start` runs the full 477 cycles.
- `start` held high through a whole operation: exactly one operation runs; a second is accepted on the first IDLE cycle after `done`.
